decode_stage: RTL and testbench

Instruction decode stage sitting directly downstream of `instruction_fetch`; consumes the fetched 32-bit MIPS-subset instruction and its PC. Holds the 32-entry architectural register file, decodes fields and control, and presents a registered ID/EX bundle to execute. Supports stall (hold), flush (bubble insert) and a writeback port with same-cycle write-to-read bypass.

---
 rtl/decode_stage.sv | 220 ++++++++++++++++++++++
 tb/tb_decode_stage.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: instruction decode for a MIPS-subset pipeline.
//   Holds the architectural register file (r0 hardwired to zero), decodes the
//   instruction handed over by fetch and registers an ID/EX bundle.
// Ports:
//   clk, reset                 rising-edge clock, async active-high reset
//   if_instruction/if_pc/      fetched instruction, its PC and valid
//   if_valid
//   stall                      hold ID/EX bundle (id_ready = ~stall)
//   flush                      load a bubble (wins over stall)
//   wb_en/wb_addr/wb_data      register file write port, bypassed to reads
//   ex_*                       registered decoded fields, operands, controls
module decode_stage #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       if_instruction,
  input  logic [DATA_W-1:0] if_pc,
  input  logic              if_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              id_ready,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc,
  output logic [5:0]        ex_opcode,
  output logic [5:0]        ex_funct,
  output logic [AW-1:0]     ex_rs,
  output logic [AW-1:0]     ex_rt,
  output logic [AW-1:0]     ex_dest,
  output logic [4:0]        ex_shamt,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_branch,
  output logic              ex_jump,
  output logic              ex_illegal
);

  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03,
                         OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_ADDI = 6'h08,
                         OP_ADDIU = 6'h09, OP_ANDI = 6'h0C, OP_ORI = 6'h0D,
                         OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_JR = 6'h08,
                         FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24,
                         FN_OR = 6'h25, FN_SLT = 6'h2A;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] pc;
    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [AW-1:0]     rs;
    logic [AW-1:0]     rt;
    logic [AW-1:0]     dest;
    logic [4:0]        shamt;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
    logic              jump;
    logic              illegal;
  } idex_t;

  // ---------------------------------------------------------------- fields
  logic [5:0]    op, fn;
  logic [AW-1:0] rs, rt, rd;
  logic [4:0]    shamt;
  logic [15:0]   imm16;
  logic [25:0]   target;

  assign op     = if_instruction[31:26];
  assign rs     = if_instruction[25:21];
  assign rt     = if_instruction[20:16];
  assign rd     = if_instruction[15:11];
  assign shamt  = if_instruction[10:6];
  assign fn     = if_instruction[5:0];
  assign imm16  = if_instruction[15:0];
  assign target = if_instruction[25:0];

  // ---------------------------------------------------------- register file
  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_en && wb_addr != '0) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Same-cycle writeback is forwarded so the captured operand is never stale.
  logic [DATA_W-1:0] rs_val, rt_val;
  always_comb begin
    rs_val = '0;
    rt_val = '0;
    if (rs != '0) rs_val = (wb_en && wb_addr == rs) ? wb_data : regs[rs];
    if (rt != '0) rt_val = (wb_en && wb_addr == rt) ? wb_data : regs[rt];
  end

  // Upper nibble of pc+4 for the jump region: it only moves when the add of 4
  // carries out of bit 27, i.e. when pc[27:2] is all ones.
  logic [3:0] pc4_hi;
  assign pc4_hi = if_pc[31:28] + {3'b000, &if_pc[27:2]};

  // ----------------------------------------------------------------- decode
  idex_t dec;
  always_comb begin
    dec           = '0;
    dec.valid     = 1'b1;
    dec.pc        = if_pc;
    dec.opcode    = op;
    dec.funct     = fn;
    dec.rs        = rs;
    dec.rt        = rt;
    dec.shamt     = shamt;
    dec.rs_data   = rs_val;
    dec.rt_data   = rt_val;
    unique case (op)
      OP_R: begin
        unique case (fn)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: begin
            dec.dest      = rd;
            dec.reg_write = 1'b1;
          end
          FN_SLL, FN_SRL: begin
            dec.dest      = rd;
            dec.reg_write = 1'b1;
            dec.imm       = {{(DATA_W-5){1'b0}}, shamt};
          end
          FN_JR: begin
            dec.dest = rd;
            dec.jump = 1'b1;
          end
          default: dec.illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        dec.dest      = rt;
        dec.reg_write = 1'b1;
        dec.imm       = {{(DATA_W-16){imm16[15]}}, imm16};
      end
      OP_ANDI, OP_ORI: begin
        dec.dest      = rt;
        dec.reg_write = 1'b1;
        dec.imm       = {{(DATA_W-16){1'b0}}, imm16};
      end
      OP_LUI: begin
        dec.dest      = rt;
        dec.reg_write = 1'b1;
        dec.imm       = {imm16, {(DATA_W-16){1'b0}}};
      end
      OP_LW: begin
        dec.dest      = rt;
        dec.reg_write = 1'b1;
        dec.mem_read  = 1'b1;
        dec.imm       = {{(DATA_W-16){imm16[15]}}, imm16};
      end
      OP_SW: begin
        dec.mem_write = 1'b1;
        dec.imm       = {{(DATA_W-16){imm16[15]}}, imm16};
      end
      OP_BEQ, OP_BNE: begin
        dec.branch = 1'b1;
        dec.imm    = {{(DATA_W-16){imm16[15]}}, imm16};
      end
      OP_J: begin
        dec.jump = 1'b1;
        dec.imm  = {pc4_hi, target, 2'b00};
      end
      OP_JAL: begin
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
        dec.dest      = AW'(31);
        dec.imm       = {pc4_hi, target, 2'b00};
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  // ---------------------------------------------------------- ID/EX bundle
  idex_t ex_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          ex_q <= '0;
    else if (flush)     ex_q <= '0;
    else if (stall)     ex_q <= ex_q;
    else if (!if_valid) ex_q <= '0;
    else                ex_q <= dec;
  end

  assign id_ready     = ~stall;
  assign ex_valid     = ex_q.valid;
  assign ex_pc        = ex_q.pc;
  assign ex_opcode    = ex_q.opcode;
  assign ex_funct     = ex_q.funct;
  assign ex_rs        = ex_q.rs;
  assign ex_rt        = ex_q.rt;
  assign ex_dest      = ex_q.dest;
  assign ex_shamt     = ex_q.shamt;
  assign ex_rs_data   = ex_q.rs_data;
  assign ex_rt_data   = ex_q.rt_data;
  assign ex_imm       = ex_q.imm;
  assign ex_reg_write = ex_q.reg_write;
  assign ex_mem_read  = ex_q.mem_read;
  assign ex_mem_write = ex_q.mem_write;
  assign ex_branch    = ex_q.branch;
  assign ex_jump      = ex_q.jump;
  assign ex_illegal   = ex_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: self-checking bench for decode_stage. A behavioural model
// (register array + per-mnemonic decode) predicts the ID/EX bundle each cycle.
module tb_decode_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_instruction, if_pc, wb_data;
  logic        if_valid, stall, flush, wb_en;
  logic [4:0]  wb_addr;
  logic        id_ready, ex_valid;
  logic [31:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm;
  logic [5:0]  ex_opcode, ex_funct;
  logic [4:0]  ex_rs, ex_rt, ex_dest, ex_shamt;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_illegal;

  decode_stage dut (
    .clk(clk), .reset(reset), .if_instruction(if_instruction), .if_pc(if_pc),
    .if_valid(if_valid), .stall(stall), .flush(flush), .wb_en(wb_en),
    .wb_addr(wb_addr), .wb_data(wb_data), .id_ready(id_ready),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_opcode(ex_opcode), .ex_funct(ex_funct),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest), .ex_shamt(ex_shamt),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, dest, shamt;
    logic [31:0] rsd, rtd, imm;
    logic        rw, mr, mw, br, jp, il;
  } bundle_t;

  int total = 0;
  int bad   = 0;
  bundle_t     exp_st;
  logic [31:0] mregs [32];

  function automatic bundle_t observed();
    return {ex_valid, ex_pc, ex_opcode, ex_funct, ex_rs, ex_rt, ex_dest, ex_shamt,
            ex_rs_data, ex_rt_data, ex_imm, ex_reg_write, ex_mem_read,
            ex_mem_write, ex_branch, ex_jump, ex_illegal};
  endfunction

  // Reference decode, written per mnemonic from the ISA description.
  function automatic bundle_t model_decode(logic [31:0] ins, logic [31:0] pc,
                                           logic [31:0] a, logic [31:0] b);
    bundle_t e;
    logic [5:0]  op  = ins[31:26];
    logic [5:0]  fn  = ins[5:0];
    logic [31:0] sx  = 32'($signed(ins[15:0]));
    logic [31:0] zx  = {16'h0, ins[15:0]};
    logic [31:0] nxt = pc + 32'd4;
    logic [31:0] jt  = {nxt[31:28], ins[25:0], 2'b00};
    e = '0;
    e.valid = 1'b1; e.pc = pc; e.op = op; e.fn = fn;
    e.rs = ins[25:21]; e.rt = ins[20:16]; e.shamt = ins[10:6];
    e.rsd = a; e.rtd = b;
    if (op == 6'h00) begin
      if (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A}) begin
        e.dest = ins[15:11]; e.rw = 1'b1;
      end else if (fn inside {6'h00, 6'h02}) begin
        e.dest = ins[15:11]; e.rw = 1'b1; e.imm = 32'(ins[10:6]);
      end else if (fn == 6'h08) begin
        e.dest = ins[15:11]; e.jp = 1'b1;
      end else e.il = 1'b1;
    end else begin
      case (op)
        6'h08, 6'h09: begin e.dest = ins[20:16]; e.rw = 1'b1; e.imm = sx; end
        6'h0C, 6'h0D: begin e.dest = ins[20:16]; e.rw = 1'b1; e.imm = zx; end
        6'h0F: begin e.dest = ins[20:16]; e.rw = 1'b1; e.imm = {ins[15:0], 16'h0}; end
        6'h23: begin e.dest = ins[20:16]; e.rw = 1'b1; e.mr = 1'b1; e.imm = sx; end
        6'h2B: begin e.mw = 1'b1; e.imm = sx; end
        6'h04, 6'h05: begin e.br = 1'b1; e.imm = sx; end
        6'h02: begin e.jp = 1'b1; e.imm = jt; end
        6'h03: begin e.jp = 1'b1; e.rw = 1'b1; e.dest = 5'd31; e.imm = jt; end
        default: e.il = 1'b1;
      endcase
    end
    return e;
  endfunction

  function automatic logic [31:0] model_read(logic [4:0] r, logic we,
                                             logic [4:0] wa, logic [31:0] wd);
    if (r == 5'd0) return 32'h0;
    if (we && wa == r) return wd;
    return mregs[r];
  endfunction

  // One clock: drive at negedge, predict, return 1 time unit after posedge.
  task automatic step(input logic [31:0] ins, input logic [31:0] pc, input logic v,
                      input logic st, input logic fl, input logic we,
                      input logic [4:0] wa, input logic [31:0] wd);
    @(negedge clk);
    if_instruction = ins; if_pc = pc; if_valid = v; stall = st; flush = fl;
    wb_en = we; wb_addr = wa; wb_data = wd;
    if (fl || (!st && !v)) exp_st = '0;
    else if (!st)
      exp_st = model_decode(ins, pc, model_read(ins[25:21], we, wa, wd),
                            model_read(ins[20:16], we, wa, wd));
    if (we && wa != 5'd0) mregs[wa] = wd;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] rfn [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02, 6'h08};
    logic [5:0] iop [9] = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05};
    logic [4:0] s = 5'($urandom_range(0, 7));
    logic [4:0] t = 5'($urandom_range(0, 7));
    logic [4:0] d = 5'($urandom_range(0, 31));
    int k = $urandom_range(0, 19);
    if (k < 7)  return {6'h00, s, t, d, 5'($urandom), rfn[$urandom_range(0, 7)]};
    if (k < 15) return {iop[$urandom_range(0, 8)], s, t, 16'($urandom)};
    if (k < 17) return {($urandom_range(0, 1) != 0) ? 6'h03 : 6'h02, 26'($urandom)};
    return $urandom;
  endfunction

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    reset = 1'b1;
    if_instruction = '0; if_pc = '0; if_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    foreach (mregs[i]) mregs[i] = '0;
    exp_st = '0;
    #1;
    total++;
    if (observed() !== bundle_t'(0)) begin
      bad++; $display("FAIL reset_outputs: got %h want 0", observed());
    end
    total++;
    if (id_ready !== 1'b1) begin
      bad++; $display("FAIL reset_id_ready: got %b want 1", id_ready);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_bypass();
    step(32'h00600820, 32'h100, 1, 0, 0, 1, 5'd3, 32'hDEADBEEF);
    total++;
    if (ex_rs_data !== 32'hDEADBEEF || ex_dest !== 5'd1 || ex_reg_write !== 1'b1) begin
      bad++; $display("FAIL bypass: got rs_data=%h dest=%0d rw=%b want deadbeef 1 1",
                      ex_rs_data, ex_dest, ex_reg_write);
    end
    step(32'h00600820, 32'h104, 1, 0, 0, 0, 5'd0, 32'h0);
    total++;
    if (ex_rs_data !== 32'hDEADBEEF || ex_pc !== 32'h104) begin
      bad++; $display("FAIL regfile_read: got rs_data=%h pc=%h want deadbeef 104",
                      ex_rs_data, ex_pc);
    end
  endtask

  task automatic test_imm();
    logic [31:0] ins [4] = '{32'h2002FFFF, 32'h3402FFFF, 32'h3C021234, 32'h0C000010};
    logic [31:0] pcs [4] = '{32'h200, 32'h204, 32'h208, 32'h40000000};
    logic [31:0] imm [4] = '{32'hFFFFFFFF, 32'h0000FFFF, 32'h12340000, 32'h40000040};
    logic [4:0]  dst [4] = '{5'd2, 5'd2, 5'd2, 5'd31};
    for (int i = 0; i < 4; i++) begin
      step(ins[i], pcs[i], 1, 0, 0, 0, 5'd0, 32'h0);
      total++;
      if (ex_imm !== imm[i] || ex_dest !== dst[i] || ex_reg_write !== 1'b1) begin
        bad++; $display("FAIL imm_%0d: got imm=%h dest=%0d rw=%b want %h %0d 1",
                        i, ex_imm, ex_dest, ex_reg_write, imm[i], dst[i]);
      end
    end
  endtask

  task automatic test_stall_flush();
    bundle_t snap;
    step(32'h00000000, 32'h2FC, 1, 0, 0, 1, 5'd2, 32'h0000_1000);
    step(32'h8C430004, 32'h300, 1, 0, 0, 0, 5'd0, 32'h0); // lw r3,4(r2)
    snap = observed();
    total++;
    if (ex_mem_read !== 1'b1 || ex_rs_data !== 32'h1000 || ex_imm !== 32'h4) begin
      bad++; $display("FAIL lw_capture: got mr=%b rs_data=%h imm=%h want 1 1000 4",
                      ex_mem_read, ex_rs_data, ex_imm);
    end
    for (int i = 0; i < 3; i++) begin
      step(32'hAC450008, 32'h304 + 32'(i * 4), 1, 1, 0, 1, 5'd2, 32'h5555_0000 + 32'(i));
      total++;
      if (observed() !== snap || id_ready !== 1'b0) begin
        bad++; $display("FAIL stall_hold_%0d: got %h ready=%b want %h ready=0",
                        i, observed(), id_ready, snap);
      end
    end
    step(32'h8C430004, 32'h310, 1, 1, 1, 0, 5'd0, 32'h0);
    total++;
    if (ex_valid !== 1'b0 || {ex_reg_write, ex_mem_read, ex_mem_write, ex_branch,
                              ex_jump, ex_illegal} !== 6'b0) begin
      bad++; $display("FAIL flush_over_stall: got valid=%b ctl=%b want 0 000000", ex_valid,
                      {ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_illegal});
    end
    step(32'h8C430004, 32'h314, 1, 0, 0, 0, 5'd0, 32'h0);
    total++;
    if (ex_rs_data !== 32'h5555_0002 || id_ready !== 1'b1 || observed() !== exp_st) begin
      bad++; $display("FAIL stall_release: got %h ready=%b want %h ready=1",
                      observed(), id_ready, exp_st);
    end
  endtask

  task automatic test_r0();
    step(32'h00000000, 32'h400, 0, 0, 0, 1, 5'd0, 32'h1234);
    step(32'h00000820, 32'h404, 1, 0, 0, 0, 5'd0, 32'h0);
    total++;
    if (ex_rs_data !== 32'h0 || ex_valid !== 1'b1) begin
      bad++; $display("FAIL r0_write: got rs_data=%h valid=%b want 0 1", ex_rs_data, ex_valid);
    end
    step(32'h00000820, 32'h408, 1, 0, 0, 1, 5'd0, 32'h5678);
    total++;
    if (ex_rs_data !== 32'h0 || ex_rt_data !== 32'h0) begin
      bad++; $display("FAIL r0_bypass: got rs=%h rt=%h want 0 0", ex_rs_data, ex_rt_data);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] ins [2] = '{32'hFC000000, 32'h0000003F};
    for (int i = 0; i < 2; i++) begin
      step(ins[i], 32'h500 + 32'(i * 4), 1, 0, 0, 0, 5'd0, 32'h0);
      total++;
      if (ex_illegal !== 1'b1 || ex_valid !== 1'b1 ||
          {ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump} !== 5'b0) begin
        bad++; $display("FAIL illegal_%0d: got il=%b valid=%b ctl=%b want 1 1 00000", i,
                        ex_illegal, ex_valid,
                        {ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump});
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(rand_instr(), $urandom, $urandom_range(0, 9) != 0,
           $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 1) != 0, 5'($urandom_range(0, 7)), $urandom);
      total++;
      if (observed() !== exp_st) begin
        bad++; $display("FAIL random_%0d: got %h want %h", i, observed(), exp_st);
      end
    end
  endtask

  task automatic test_reset_mid();
    step(32'h00000000, 32'h600, 0, 0, 0, 1, 5'd5, 32'hCAFE_F00D);
    step(32'h00A00820, 32'h604, 1, 0, 0, 0, 5'd0, 32'h0); // add r1,r5,r0
    total++;
    if (ex_valid !== 1'b1 || ex_rs_data !== 32'hCAFEF00D) begin
      bad++; $display("FAIL pre_reset: got valid=%b rs=%h want 1 cafef00d", ex_valid, ex_rs_data);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if (observed() !== bundle_t'(0)) begin
      bad++; $display("FAIL async_reset: got %h want 0", observed());
    end
    foreach (mregs[i]) mregs[i] = '0;
    exp_st = '0;
    @(negedge clk);
    stall = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    step(32'h00A00820, 32'h608, 1, 1, 0, 0, 5'd0, 32'h0);
    total++;
    if (observed() !== bundle_t'(0)) begin
      bad++; $display("FAIL release_in_stall: got %h want 0", observed());
    end
    step(32'h00A00820, 32'h60C, 1, 0, 0, 0, 5'd0, 32'h0);
    total++;
    if (ex_rs_data !== 32'h0 || ex_valid !== 1'b1 || observed() !== exp_st) begin
      bad++; $display("FAIL r5_after_reset: got rs=%h valid=%b want 0 1", ex_rs_data, ex_valid);
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_imm();
    test_stall_flush();
    test_r0();
    test_illegal();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion want finish");
    $fatal(1);
  end
endmodule
